// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : seq_det_ctrl_if -- config, run-control and serial-stream bundle
// Rev    : 1.0
// ============================================================================
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               start;
  logic [FRAME_W-1:0] frame_len;
  logic               x_valid;
  logic               x;
  logic               z;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic [FRAME_W-1:0] first_match_idx;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len, x_valid, x,
    input  cfg_err, z, busy, done, match_count, first_match_idx
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len, x_valid, x,
    output cfg_err, z, busy, done, match_count, first_match_idx
  );
endinterface
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seq_det_ctrl -- run-controlled programmable Moore sequence detector
// Rev    : 1.0
// ============================================================================
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [MAX_LEN-1:0] c_rst_pattern = MAX_LEN'(4'b1001);
  localparam logic [LEN_W-1:0]   c_rst_len     = LEN_W'(4);
  localparam logic [LEN_W:0]     c_max_len     = (LEN_W+1)'(MAX_LEN);
  localparam logic [FRAME_W-1:0] c_no_match    = '1;
  localparam logic [CNT_W-1:0]   c_cnt_max     = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [FRAME_W-1:0] r_idx;
  logic [FRAME_W-1:0] r_flen;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_first;
  logic               r_z;
  logic               r_cfg_err;

  logic               w_len_ok;
  logic               w_cfg_wr;
  logic               w_accept;
  logic               w_match;
  logic               w_last;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W-1:0]   w_fill_nxt;

  always_comb begin
    w_len_ok   = (bus.cfg_len != '0) && ({1'b0, bus.cfg_len} <= c_max_len);
    w_cfg_wr   = bus.cfg_we && (r_state == S_IDLE) && w_len_ok;
    w_accept   = (r_state == S_RUN) && bus.x_valid;
    w_hist_nxt = {r_hist[MAX_LEN-2:0], bus.x};
    // Shifting all-ones by len leaves ones only above the active pattern bits.
    w_mask     = ~({MAX_LEN{1'b1}} << r_len);
    w_fill_inc = {1'b0, r_fill} + 1'b1;
    w_fill_nxt = (w_fill_inc > c_max_len) ? LEN_W'(c_max_len) : LEN_W'(w_fill_inc);
    w_match    = (w_fill_inc >= {1'b0, r_len}) &&
                 (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
    w_last     = (r_idx == (r_flen - 1'b1));

    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.frame_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= c_rst_pattern;
      r_len     <= c_rst_len;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_flen    <= '0;
      r_cnt     <= '0;
      r_first   <= c_no_match;
      r_z       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_we && !w_cfg_wr;
      r_z       <= 1'b0;
      if (w_cfg_wr) begin
        r_pattern <= bus.cfg_pattern;
        r_len     <= bus.cfg_len;
        r_overlap <= bus.cfg_overlap;
      end
      if ((r_state == S_IDLE) && bus.start) begin
        r_cnt   <= '0;
        r_first <= c_no_match;
        r_hist  <= '0;
        r_fill  <= '0;
        r_idx   <= '0;
        r_flen  <= bus.frame_len;
      end
      if (w_accept) begin
        r_idx <= r_idx + 1'b1;
        // Non-overlapping mode restarts the search from an empty history.
        if (w_match && !r_overlap) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_nxt;
          r_fill <= w_fill_nxt;
        end
        if (w_match) begin
          r_z <= 1'b1;
          if (r_cnt != c_cnt_max)    r_cnt   <= r_cnt + 1'b1;
          if (r_first == c_no_match) r_first <= r_idx;
        end
      end
    end
  end

  assign bus.z               = r_z;
  assign bus.busy            = (r_state == S_RUN);
  assign bus.done            = (r_state == S_DONE);
  assign bus.cfg_err         = r_cfg_err;
  assign bus.match_count     = r_cnt;
  assign bus.first_match_idx = r_first;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// tb_seq_det_ctrl: directed and randomized checks of seq_det_ctrl against a
// queue-based reference of the detector rules.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int FRAME_W = 8;
  localparam int CNT_W   = 8;
  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DONE  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FRAME_W(FRAME_W), .CNT_W(CNT_W)) bus ();
  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    z_seen   = 0;
  string t_name   = "init";

  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_phase;
  bit         seg[$];
  int         m_cnt, m_first, m_idx, m_flen;
  bit         m_z, m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got=%0h exp=%0h @%0t", t_name, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b0000_1001; m_len = 4; m_ovl = 1'b0;
    m_phase = P_IDLE; seg.delete();
    m_cnt = 0; m_first = 255; m_idx = 0; m_flen = 0;
    m_z = 1'b0; m_err = 1'b0;
  endtask

  // Predicts the effect of the edge about to happen from the current inputs.
  task automatic model_step();
    bit hit;
    if (rst) begin
      model_reset();
      return;
    end
    m_err = bus.cfg_we && (m_phase != P_IDLE || bus.cfg_len == 0 || int'(bus.cfg_len) > MAX_LEN);
    m_z   = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (bus.cfg_we && !m_err) begin
          m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_ovl = bus.cfg_overlap;
        end
        if (bus.start) begin
          m_cnt = 0; m_first = 255; seg.delete(); m_idx = 0;
          m_flen  = int'(bus.frame_len);
          m_phase = (m_flen == 0) ? P_DONE : P_RUN;
        end
      end
      P_RUN: begin
        if (bus.x_valid) begin
          seg.push_back(bus.x);
          hit = (seg.size() >= m_len);
          for (int i = 0; i < m_len && hit; i++)
            if (seg[seg.size()-1-i] != m_pat[i]) hit = 1'b0;
          if (hit) begin
            m_z = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (m_first == 255) m_first = m_idx;
            if (!m_ovl) seg.delete();
          end
          if (m_idx == m_flen - 1) m_phase = P_DONE;
          m_idx++;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (bus.z === 1'b1) z_seen++;
    check_val("z",     32'(bus.z),               32'(m_z));
    check_val("busy",  32'(bus.busy),            32'(m_phase == P_RUN));
    check_val("done",  32'(bus.done),            32'(m_phase == P_DONE));
    check_val("err",   32'(bus.cfg_err),         32'(m_err));
    check_val("count", 32'(bus.match_count),     32'(m_cnt));
    check_val("first", 32'(bus.first_match_idx), 32'(m_first));
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.start = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
  endtask

  task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ovl; bus.cfg_we = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] fl);
    bus.frame_len = fl; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_stream(input logic [63:0] bits, input int n, input int gaps);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps; g++) begin
        bus.x_valid = 1'b0; bus.x = 1'($urandom_range(0, 1));
        tick();
      end
      bus.x_valid = 1'b1; bus.x = bits[n-1-i];
      tick();
    end
    bus.x_valid = 1'b0; bus.x = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 4 && m_phase != P_IDLE; c++) tick();
    check_val("drain_idle", 32'(m_phase), 32'(P_IDLE));
  endtask

  initial begin
    logic [63:0] stream;
    stream = 64'b0100100101001;
    rst = 1'b1;
    idle_inputs();
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.frame_len = '0;
    model_reset();
    t_name = "reset";
    tick(); tick();
    rst = 1'b0;
    check_val("rst_first", 32'(bus.first_match_idx), 32'hFF);
    check_val("rst_count", 32'(bus.match_count), 32'd0);

    t_name = "t1_nonovl"; z_seen = 0;
    start_frame(8'd13); send_stream(stream, 13, 0); drain();
    check_val("count", 32'(bus.match_count), 32'd2);
    check_val("first", 32'(bus.first_match_idx), 32'd4);
    check_val("zpulses", 32'(z_seen), 32'd2);

    t_name = "t2_ovl"; z_seen = 0;
    write_cfg(8'b1001, 4'd4, 1'b1);
    start_frame(8'd13); send_stream(stream, 13, 0); drain();
    check_val("count", 32'(bus.match_count), 32'd3);
    check_val("zpulses", 32'(z_seen), 32'd3);

    t_name = "t3_gaps"; z_seen = 0;
    start_frame(8'd4); send_stream(64'b1001, 4, 2); drain();
    check_val("count", 32'(bus.match_count), 32'd1);
    check_val("first", 32'(bus.first_match_idx), 32'd3);

    t_name = "t4_cfg"; z_seen = 0;
    write_cfg(8'b1001, 4'd4, 1'b0);
    write_cfg(8'b1111, 4'd0, 1'b1);
    check_val("len0_err", 32'(bus.cfg_err), 32'd1);
    start_frame(8'd4);
    bus.x_valid = 1'b1; bus.x = 1'b1; tick();
    bus.cfg_pattern = 8'b1111; bus.cfg_len = 4'd4; bus.cfg_overlap = 1'b1; bus.cfg_we = 1'b1;
    bus.x = 1'b0; tick();
    bus.cfg_we = 1'b0;
    check_val("run_err", 32'(bus.cfg_err), 32'd1);
    bus.x = 1'b0; tick();
    bus.x = 1'b1; tick();
    idle_inputs(); drain();
    check_val("count", 32'(bus.match_count), 32'd1);
    write_cfg(8'b110, 4'd3, 1'b0);
    start_frame(8'd6); send_stream(64'b110110, 6, 0); drain();
    check_val("count110", 32'(bus.match_count), 32'd2);

    t_name = "t5_zero"; z_seen = 0;
    start_frame(8'd0);
    check_val("done", 32'(bus.done), 32'd1);
    drain();
    check_val("count", 32'(bus.match_count), 32'd0);
    check_val("first", 32'(bus.first_match_idx), 32'hFF);
    check_val("zpulses", 32'(z_seen), 32'd0);

    t_name = "t6_rst";
    write_cfg(8'b0110, 4'd4, 1'b1);
    start_frame(8'd13); send_stream(64'b010010, 6, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("busy", 32'(bus.busy), 32'd0);
    check_val("done", 32'(bus.done), 32'd0);
    check_val("count", 32'(bus.match_count), 32'd0);
    tick();
    z_seen = 0;
    start_frame(8'd13); send_stream(stream, 13, 0); drain();
    check_val("count_dflt", 32'(bus.match_count), 32'd2);
    check_val("first_dflt", 32'(bus.first_match_idx), 32'd4);

    t_name = "random";
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 1) == 1)
        write_cfg(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      start_frame(8'($urandom_range(0, 40)));
      for (int c = 0; c < 400 && m_phase != P_IDLE; c++) begin
        bus.x_valid     = ($urandom_range(0, 3) != 0);
        bus.x           = 1'($urandom_range(0, 1));
        bus.cfg_we      = ($urandom_range(0, 15) == 0);
        bus.cfg_pattern = 8'($urandom);
        bus.cfg_len     = 4'($urandom_range(1, 8));
        bus.cfg_overlap = 1'($urandom_range(0, 1));
        bus.start       = ($urandom_range(0, 7) == 0);
        bus.frame_len   = 8'($urandom);
        rst             = ($urandom_range(0, 299) == 0);
        tick();
      end
      idle_inputs();
      rst = 1'b0;
      check_val("frame_end", 32'(m_phase), 32'(P_IDLE));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Run-controlled, programmable Moore serial sequence detector with a configuration interface.
- Software writes a pattern (1..MAX_LEN bits), its length and an overlap mode, then starts a frame-scan of frame_len serial bits.
- Each completed match produces a Moore pulse on z, increments a match counter and records the first-match index.
- Generalises the fixed 1001 overlapping/non-overlapping detectors into one schedulable resource with start/busy/done handshake.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- LEN_W, 4, width of cfg_len; must be able to hold MAX_LEN.
- FRAME_W, 8, width of frame_len and the bit index.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  configuration write strobe.
- cfg_pattern  input  MAX_LEN  pattern bits; pattern[len-1] is the first bit received, pattern[0] the last.
- cfg_len  input  LEN_W  pattern length, 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_err  output  1  one-cycle pulse: write rejected.
- start  input  1  begin a frame-scan (honoured in IDLE only).
- frame_len  input  FRAME_W  number of bits to scan; sampled on start.
- x_valid  input  1  serial bit qualifier.
- x  input  1  serial data bit.
- z  output  1  registered Moore match pulse.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- match_count  output  CNT_W  matches in current/last frame, saturating.
- first_match_idx  output  FRAME_W  index (0-based) of the bit completing the first match; all-ones if none.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state IDLE; pattern = 1001 (low 4 bits, rest 0); len = 4; overlap = 0.
  - z, busy, done, cfg_err = 0; match_count = 0; first_match_idx = all-ones.
  - history cleared.
- State machine: IDLE, RUN, DONE.
- Configuration:
  - cfg_we in IDLE with 1 <= cfg_len <= MAX_LEN: latch pattern, len and overlap at that edge.
  - cfg_len = 0 or cfg_len > MAX_LEN: write ignored; cfg_err pulses the next cycle.
  - cfg_we outside IDLE: ignored and pulses cfg_err.
  - cfg_we and start in the same IDLE cycle: config is applied first; the frame uses the new config.
- IDLE -> RUN on start:
  - clear match_count, history, bit index and fill counter.
  - set first_match_idx to all-ones; latch frame_len.
  - if frame_len = 0, go directly IDLE -> DONE.
- RUN, one bit accepted per edge with x_valid = 1 (x_valid = 0 means no state change):
  - history shifts left, taking in x; fill = min(fill+1, MAX_LEN).
  - match = (fill+1 >= len) and the low len bits of the new history equal pattern[len-1:0].
  - on match:
    - z = 1 for the next cycle only;
    - match_count += 1, saturating at 2^CNT_W-1;
    - first_match_idx = bit index if still all-ones;
    - if overlap = 0, fill is cleared to 0 and history is cleared.
  - no match: z = 0 next cycle.
  - bit index increments; when the accepted bit is index frame_len-1, next state is DONE.
  - start in RUN is ignored.
- DONE:
  - done = 1 and busy = 0 for one cycle.
  - z may be high in this cycle if the last bit matched.
  - match_count and first_match_idx hold; next state IDLE.
- IDLE: match_count and first_match_idx hold until the next start; x/x_valid are ignored and z = 0.
- Reset mid-RUN: the next cycle is in the reset state with config restored to defaults; no done pulse.
- Latency: input bit at edge k gives z at edge k+1; done is asserted in the cycle after the final bit's edge.

Test Plan:
1. Reset defaults, non-overlap:
   - Stimulus: start, frame_len = 13, stream 0100100101001 with x_valid = 1 every cycle.
   - Required: z pulses after bit indices 4 and 12; done pulses; match_count = 2; first_match_idx = 4.
2. Overlap mode:
   - Stimulus: write pattern 1001, len 4, overlap 1; same stream.
   - Required: z after indices 4, 7, 12; match_count = 3.
3. x_valid gaps:
   - Stimulus: 1001 with x_valid = 0 cycles inserted between bits, and x toggling during the gaps.
   - Required: exactly one match; busy stays 1 until the 4th accepted bit; match_count = 1.
4. Config rules:
   - Stimulus: cfg_we with cfg_len = 0 in IDLE, then cfg_we with a valid length during RUN.
   - Required: both pulse cfg_err; a frame 1001 still yields one match under the original config.
   - Stimulus: pattern 3'b110, len 3, overlap 0, stream 110110.
   - Required: match_count = 2.
5. frame_len = 0:
   - Stimulus: start with frame_len = 0.
   - Required: done next cycle, match_count = 0, first_match_idx = 8'hFF, no z.
6. Reset mid-RUN:
   - Stimulus: rst asserted after 6 bits.
   - Required: busy = 0, match_count = 0, config back to 1001/len 4/non-overlap, no done; a new frame then works.
